// File: rtl/fetch_unit.sv
// fetch_unit: PC register plus a single-entry IF/ID register feeding decode.
// Latency: word at address A appears on out_instr one cycle after pc_out=A; a redirect
// leaves exactly one bubble. Backpressure: out_ready=0 while full freezes PC and IF/ID.
// Ports: clk/rst (async active-high); pc_out/instruction_in form the combinational memory
// port; redirect_valid/redirect_pc steer the PC; out_* is the valid/ready stream to decode;
// misalign_err pulses for one cycle after a misaligned redirect (FETCH_ALIGN_CHECK_EN only).
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, redirect targets have
// bits [1:0] cleared and misaligned targets are flagged. When it is undefined, targets are
// used as given and misalign_err is always 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] instruction_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_next,
  output logic        misalign_err
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] redirect_target;
  logic        misalign_nxt;
  logic        capture;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign misalign_nxt    = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_target = redirect_pc;
  assign misalign_nxt    = 1'b0;
`endif

  // Redirect wins over everything. A transfer in the same cycle is still
  // consumed by decode; only the word fetched this cycle is dropped.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    if (redirect_valid) begin
      state_nxt = EMPTY;
      pc_nxt    = redirect_target;
    end else if (state == EMPTY || out_ready) begin
      capture   = 1'b1;
      state_nxt = FULL;
      pc_nxt    = pc + STEP;   // wraps modulo 2^32
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      misalign_err <= misalign_nxt;
    end
  end

  // Payload only moves on capture, so it stays stable through stalls and bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_instr   <= 32'h0;
      out_pc      <= 32'h0;
      out_pc_next <= 32'h0;
    end else if (capture) begin
      out_instr   <= instruction_in;
      out_pc      <= pc;
      out_pc_next <= pc + STEP;
    end
  end

  assign pc_out    = pc;
  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_out, instruction_in, redirect_pc, out_instr, out_pc, out_pc_next;
  logic        redirect_valid = 1'b0, out_ready = 1'b0, out_valid, misalign_err;

  int nvec = 0;
  int nerr = 0;

  // Reference state: next fetch address, IF/ID fullness, pending error pulse,
  // and the program-order address decode must consume next.
  logic [31:0] m_fetch;
  logic        m_valid, m_err;
  logic [31:0] seq_ptr;

  fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .instruction_in(instruction_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Instruction memory: a distinct word for every address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign instruction_in = mem_word(pc_out);

  function automatic logic [31:0] exp_target(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
    return {t[31:2], 2'b00};
`else
    return t;
`endif
  endfunction

  function automatic logic exp_misalign(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Apply one cycle of inputs, advance the reference, then settle 1ns past the edge.
  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    if (rv) begin
      m_fetch = exp_target(rpc);
      m_valid = 1'b0;
      m_err   = exp_misalign(rpc);
    end else begin
      m_err = 1'b0;
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_fetch = m_fetch + 32'd4;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    m_fetch = RST_PC;
    m_valid = 1'b0;
    m_err   = 1'b0;
    seq_ptr = RST_PC;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (pc_out !== RST_PC || out_valid !== 1'b0 || misalign_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ctrl: pc_out=%h out_valid=%b misalign_err=%b, required %h 0 0",
               pc_out, out_valid, misalign_err, RST_PC);
    end
    nvec++;
    if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_pc_next !== 32'h0) begin
      nerr++;
      $display("FAIL reset_data: instr=%h pc=%h pc_next=%h, required all zero",
               out_instr, out_pc, out_pc_next);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 32'h0, 1'b1);
      nvec++;
      if (out_valid !== 1'b1 || out_instr !== mem_word(32'(4 * k)) ||
          out_pc !== 32'(4 * k) || out_pc_next !== 32'(4 * k + 4)) begin
        nerr++;
        $display("FAIL seq_w%0d: valid=%b instr=%h pc=%h next=%h, required 1 %h %h %h",
                 k, out_valid, out_instr, out_pc, out_pc_next,
                 mem_word(32'(4 * k)), 32'(4 * k), 32'(4 * k + 4));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_pc, held_fetch;
    held_pc    = out_pc;
    held_fetch = m_fetch;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 32'h0, 1'b0);
      nvec++;
      if (out_valid !== 1'b1 || pc_out !== held_fetch || out_pc !== held_pc ||
          out_instr !== mem_word(held_pc)) begin
        nerr++;
        $display("FAIL stall_hold%0d: valid=%b pc_out=%h out_pc=%h instr=%h, required 1 %h %h %h",
                 k, out_valid, pc_out, out_pc, out_instr, held_fetch, held_pc, mem_word(held_pc));
      end
    end
    cycle(1'b0, 32'h0, 1'b1);
    nvec++;
    if (out_valid !== 1'b1 || out_pc !== held_pc + 32'd4 || out_instr !== mem_word(held_pc + 32'd4)) begin
      nerr++;
      $display("FAIL stall_release: valid=%b out_pc=%h instr=%h, required 1 %h %h",
               out_valid, out_pc, out_instr, held_pc + 32'd4, mem_word(held_pc + 32'd4));
    end
  endtask

  task automatic test_redirect();
    cycle(1'b1, 32'h40, 1'b1);
    nvec++;
    if (out_valid !== 1'b0 || pc_out !== 32'h40) begin
      nerr++;
      $display("FAIL redirect_bubble: valid=%b pc_out=%h, required 0 00000040", out_valid, pc_out);
    end
    cycle(1'b0, 32'h0, 1'b1);
    nvec++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== mem_word(32'h40)) begin
      nerr++;
      $display("FAIL redirect_first: valid=%b out_pc=%h instr=%h, required 1 00000040 %h",
               out_valid, out_pc, out_instr, mem_word(32'h40));
    end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    nvec++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_pc_next !== 32'h0 || pc_out !== 32'h0) begin
      nerr++;
      $display("FAIL wrap: valid=%b out_pc=%h next=%h pc_out=%h, required 1 fffffffc 00000000 00000000",
               out_valid, out_pc, out_pc_next, pc_out);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] want_pc;
    logic        want_err;
`ifdef FETCH_ALIGN_CHECK_EN
    want_pc = 32'h44; want_err = 1'b1;
`else
    want_pc = 32'h46; want_err = 1'b0;
`endif
    cycle(1'b1, 32'h46, 1'b0);
    nvec++;
    if (pc_out !== want_pc || misalign_err !== want_err || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL misalign_redirect: pc_out=%h err=%b valid=%b, required %h %b 0",
               pc_out, misalign_err, out_valid, want_pc, want_err);
    end
    cycle(1'b0, 32'h0, 1'b1);
    nvec++;
    if (misalign_err !== 1'b0 || out_pc !== want_pc || out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL misalign_pulse_end: err=%b out_pc=%h valid=%b, required 0 %h 1",
               misalign_err, out_pc, out_valid, want_pc);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);   // FULL and stalled
    #2;                          // mid-cycle, no edge in sight
    rst = 1'b1;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || pc_out !== RST_PC || out_instr !== 32'h0 || out_pc !== 32'h0) begin
      nerr++;
      $display("FAIL async_reset: valid=%b pc_out=%h instr=%h out_pc=%h, required 0 %h 0 0",
               out_valid, pc_out, out_instr, out_pc, RST_PC);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 32'h0, 1'b1);
    nvec++;
    if (out_valid !== 1'b1 || out_pc !== RST_PC || out_instr !== mem_word(RST_PC)) begin
      nerr++;
      $display("FAIL async_reset_restart: valid=%b out_pc=%h instr=%h, required 1 %h %h",
               out_valid, out_pc, out_instr, RST_PC, mem_word(RST_PC));
    end
  endtask

  task automatic test_random();
    logic        rv, rdy;
    logic [31:0] rpc;
    rpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    cycle(1'b1, rpc, 1'b0);
    seq_ptr = exp_target(rpc);
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = $urandom();
      if ($urandom_range(0, 1) == 0) rpc[1:0] = 2'b00;
      redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
      // Every word decode takes must be the next one in program order.
      if (out_valid === 1'b1 && rdy) begin
        nvec++;
        if (out_pc !== seq_ptr) begin
          nerr++;
          $display("FAIL rand_order[%0d]: consumed pc=%h, required %h", i, out_pc, seq_ptr);
        end
        seq_ptr = seq_ptr + 32'd4;
      end
      if (rv) seq_ptr = exp_target(rpc);
      cycle(rv, rpc, rdy);
      nvec++;
      if (out_valid !== m_valid || pc_out !== m_fetch || misalign_err !== m_err) begin
        nerr++;
        $display("FAIL rand_state[%0d]: valid=%b pc_out=%h err=%b, required %b %h %b",
                 i, out_valid, pc_out, misalign_err, m_valid, m_fetch, m_err);
      end
      if (out_valid === 1'b1) begin
        nvec++;
        if (out_instr !== mem_word(out_pc) || out_pc_next !== out_pc + 32'd4) begin
          nerr++;
          $display("FAIL rand_payload[%0d]: pc=%h instr=%h next=%h, required %h %h",
                   i, out_pc, out_instr, out_pc_next, mem_word(out_pc), out_pc + 32'd4);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    redirect_pc = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_misalign();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
